// File: rtl/sixbit_result_bcd.sv
// Sequential signed-binary to two-digit BCD converter for the divider result.
// Magnitude is converted by shift-add-3, one bit per clock; sign and error flag travel alongside.
module sixbit_result_bcd #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   input  logic             err_in,
   output logic             busy,
   output logic             done,
   output logic             neg,
   output logic [3:0]       tens,
   output logic [3:0]       ones,
   output logic             err_out
);

   // Two BCD digits only cover magnitudes up to 99, so WIDTH must stay within 2..7.
   generate
      if (WIDTH < 2 || WIDTH > 7) begin : g_bad_width
         $error("sixbit_result_bcd: WIDTH must be in 2..7");
      end
   endgenerate

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                  state;
   logic        [WIDTH-1:0] mag;
   logic        [7:0]       bcd;
   logic                    sign;
   logic        [CNT_W-1:0] count;

   logic signed [WIDTH-1:0] sval;
   logic        [WIDTH-1:0] abs_val;
   logic        [7:0]       bcd_adj;
   logic        [7:0]       bcd_nxt;
   logic        [WIDTH-1:0] mag_nxt;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   // The most negative input wraps to 2^(WIDTH-1), which is exactly its unsigned magnitude.
   always_comb begin
      sval    = value;
      abs_val = sval[WIDTH-1] ? -sval : sval;
      bcd_adj = {add3(bcd[7:4]), add3(bcd[3:0])};
      bcd_nxt = {bcd_adj[6:0], mag[WIDTH-1]};
      mag_nxt = {mag[WIDTH-2:0], 1'b0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         neg     <= 1'b0;
         tens    <= 4'd0;
         ones    <= 4'd0;
         err_out <= 1'b0;
         mag     <= '0;
         bcd     <= '0;
         sign    <= 1'b0;
         count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  if (err_in) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     neg     <= 1'b0;
                     tens    <= 4'd0;
                     ones    <= 4'd0;
                     err_out <= 1'b1;
                  end else begin
                     state <= SHIFT;
                     mag   <= abs_val;
                     sign  <= value[WIDTH-1];
                     bcd   <= '0;
                     count <= CNT_W'(WIDTH - 1);
                  end
               end
            end
            SHIFT: begin
               bcd   <= bcd_nxt;
               mag   <= mag_nxt;
               count <= count - 1'b1;
               // Final shift: publish the fully shifted digits so they appear in the done cycle.
               if (count == '0) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  neg     <= sign;
                  tens    <= bcd_nxt[7:4];
                  ones    <= bcd_nxt[3:0];
                  err_out <= 1'b0;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
